// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte requesters. Requesters
//   are served round-robin. A packet lock keeps the grant on one requester
//   until the byte marked req_last has been accepted. Each byte is issued to
//   the transmitter with a one-cycle tx_data_valid pulse. The arbiter then
//   waits for tx_busy to rise, and then to fall, before the next selection.
//   If tx_busy does not rise within ACK_TIMEOUT cycles, the sticky
//   timeout_err flag is set and the lock is dropped.
//
// Ports
//   clk              : clock; all logic runs on its rising edge
//   reset            : asynchronous, active-low reset
//   req_valid        : per-requester byte available
//   req_data         : requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last         : per-requester "final byte of packet" marker
//   req_ready        : one-hot acceptance strobe (combinational, IDLE only)
//   tx_data_valid    : one-cycle issue pulse to the transmitter
//   tx_parallel_data : byte to the transmitter, held until the next acceptance
//   tx_busy          : transmitter busy
//   grant_id         : current or last granted requester
//   locked           : packet lock active
//   timeout_err      : sticky flag; the transmitter failed to start
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_parallel_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          locked,
    output logic                          timeout_err
);

    localparam int          GW = $clog2(NUM_REQ);
    localparam int          CW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned NR = NUM_REQ;
    localparam logic [GW-1:0] LAST_ID  = GW'(NUM_REQ - 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         ack_cnt;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
    logic                  sel_found;
    logic [GW-1:0]         sel_idx;
    logic [GW-1:0]         cand;
    logic                  accept;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // While locked, only the holder may be selected. Otherwise the search
    // starts one past the last grant, so the last grant is tried last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = grant_id;
        cand      = grant_id;
        if (locked) begin
            sel_found = req_valid[grant_id];
        end else begin
            for (int unsigned k = 1; k <= NR; k++) begin
                cand = GW'((32'(grant_id) + k) % NR);
                if (!sel_found && req_valid[cand]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
    end

    // Acceptance is the handshake cycle itself. req_ready must be visible in
    // that cycle, so it is decoded from the state rather than registered.
    assign accept = reset && (state == IDLE) && !tx_busy && sel_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            ack_cnt          <= '0;
            tx_data_valid    <= 1'b0;
            tx_parallel_data <= '0;
            grant_id         <= LAST_ID;
            locked           <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            tx_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_parallel_data <= req_bytes[sel_idx];
                        grant_id         <= sel_idx;
                        locked           <= !req_last[sel_idx];
                        tx_data_valid    <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack_cnt <= '0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. A behavioural model tracks the
//   in-flight byte, grant pointer, lock and error flag from the arbitration
//   rules. It is compared against every DUT output on each falling edge.
//   Directed scenarios pin the model with literal expectations. A
//   randomized phase follows.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int ACK_TIMEOUT = 15;
    localparam int GW          = $clog2(NUM_REQ);

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]            req_last = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_data_valid;
    logic [DATA_WIDTH-1:0]         tx_parallel_data;
    logic                          tx_busy;
    logic [GW-1:0]                 grant_id;
    logic                          locked;
    logic                          timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .tx_data_valid   (tx_data_valid),
        .tx_parallel_data(tx_parallel_data),
        .tx_busy         (tx_busy),
        .grant_id        (grant_id),
        .locked          (locked),
        .timeout_err     (timeout_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    int              m_grant;
    bit              m_locked, m_terr, m_inflight, m_issue, m_started;
    int              m_wait;
    logic [7:0]      m_data;
    int              n_accept = 0;
    int              mp;
    int              grant_log[$];
    logic [7:0]      data_log[$];
    bit              lock_log[$];

    function automatic int model_pick();
        if (m_locked) return req_valid[m_grant] ? m_grant : -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_grant + k) % NUM_REQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_grant = NUM_REQ - 1; m_locked = 0; m_terr = 0;
            m_inflight = 0; m_issue = 0; m_started = 0; m_wait = 0; m_data = '0;
        end else if (!m_inflight) begin
            mp = model_pick();
            if (!tx_busy && mp >= 0) begin
                m_grant    = mp;
                m_data     = req_data[mp*DATA_WIDTH +: DATA_WIDTH];
                m_locked   = !req_last[mp];
                m_inflight = 1; m_issue = 1; m_started = 0; m_wait = 0;
                n_accept++;
                grant_log.push_back(mp);
                data_log.push_back(m_data);
                lock_log.push_back(m_locked);
            end
        end else if (m_issue) begin
            m_issue = 0;
        end else if (!m_started) begin
            if (tx_busy) m_started = 1;
            else begin
                m_wait++;
                if (m_wait == ACK_TIMEOUT) begin
                    m_terr = 1; m_locked = 0; m_inflight = 0;
                end
            end
        end else if (!tx_busy) begin
            m_inflight = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    int n_dv = 0;

    always @(negedge clk) begin : cmp_blk
        int p;
        logic [NUM_REQ-1:0] er;
        if (chk_en) begin
            p  = model_pick();
            er = '0;
            if (reset && !m_inflight && !tx_busy && p >= 0) er[p] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(er));
            check("tx_data_valid", 32'(tx_data_valid), 32'(m_inflight && m_issue));
            check("tx_parallel_data", 32'(tx_parallel_data), 32'(m_data));
            check("grant_id", 32'(grant_id), 32'(m_grant));
            check("locked", 32'(locked), 32'(m_locked));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
            if (tx_data_valid) n_dv++;
        end
    end

    // ---------------- transmitter model ----------------
    int tx_mode  = 0;   // 0: responds to tx_data_valid, 1: never starts
    bit tx_force = 0;   // external busy override
    int tx_delay = 0;
    int tx_len   = 10;
    int wait_left = 0, run_left = 0;
    bit armed = 0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_valid && tx_mode == 0) begin
                armed = 1; wait_left = tx_delay;
            end
            @(posedge clk); #2;
            if (armed) begin
                if (wait_left == 0) begin armed = 0; run_left = tx_len; end
                else wait_left--;
            end
            tx_busy = tx_force || (run_left > 0);
            if (run_left > 0) run_left--;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i] = v;
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
        req_last[i] = l;
    endtask

    task automatic wait_accepts(input int target, input int maxc, input string name);
        int c;
        c = 0;
        while (n_accept < target && c < maxc) begin tick(); c++; end
        if (n_accept < target) bound_fail(name);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int c;
        c = 0;
        while ((m_inflight || tx_busy || armed) && c < maxc) begin tick(); c++; end
        if (m_inflight || tx_busy || armed) bound_fail(name);
    endtask

    task automatic wait_ready(input int idx, input int maxc, input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (!req_ready[idx] && c < maxc) begin @(negedge clk); c++; end
        if (!req_ready[idx]) bound_fail(name);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int base, dv0, r2i, c, frc_left;
        bit got0, got2, done0;

        // Reset values
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_tx_dv", 32'(tx_data_valid), 32'h0);
        check("rst_tx_data", 32'(tx_parallel_data), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'(NUM_REQ - 1));
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk_en = 1;

        // All requesters valid, single-byte packets: rotation 0,1,2,3,0
        tx_delay = 0; tx_len = 10;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 8'(8'h10 + i), 1);
        base = grant_log.size();
        dv0  = n_dv;
        @(negedge clk);
        check("first_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("first_grant", 32'(grant_id), 32'h0);
        check("first_dv", 32'(tx_data_valid), 32'h1);
        check("first_data", 32'(tx_parallel_data), 32'h10);
        wait_accepts(base + 5, 200, "rr_accepts");
        req_valid = '0;
        wait_idle(100, "rr_idle");
        if (grant_log.size() >= base + 5) begin
            check("rr_g0", 32'(grant_log[base]),   32'd0);
            check("rr_g1", 32'(grant_log[base+1]), 32'd1);
            check("rr_g2", 32'(grant_log[base+2]), 32'd2);
            check("rr_g3", 32'(grant_log[base+3]), 32'd3);
            check("rr_g4", 32'(grant_log[base+4]), 32'd0);
        end
        check("rr_dv_count", 32'(n_dv - dv0), 32'd5);

        // Locked 3-byte packet from requester 2 while requester 0 waits
        tx_len = 4;
        set_req(0, 1, 8'h55, 1);
        set_req(2, 1, 8'hA1, 0);
        r2i = 0; done0 = 0;
        base = grant_log.size();
        for (int k = 0; k < 300 && !done0; k++) begin
            @(negedge clk);
            got2 = req_ready[2];
            got0 = req_ready[0];
            tick();
            if (got2) begin
                r2i++;
                if (r2i < 3) set_req(2, 1, 8'(8'hA1 + r2i), r2i == 2);
                else set_req(2, 0, 8'h00, 0);
            end
            if (got0) begin set_req(0, 0, 8'h00, 0); done0 = 1; end
        end
        if (!done0) bound_fail("lock_seq");
        wait_idle(100, "lock_idle");
        if (grant_log.size() >= base + 4) begin
            check("lock_g0", 32'(grant_log[base]),   32'd2);
            check("lock_g1", 32'(grant_log[base+1]), 32'd2);
            check("lock_g2", 32'(grant_log[base+2]), 32'd2);
            check("lock_g3", 32'(grant_log[base+3]), 32'd0);
            check("lock_d0", 32'(data_log[base]),   32'hA1);
            check("lock_d1", 32'(data_log[base+1]), 32'hA2);
            check("lock_d2", 32'(data_log[base+2]), 32'hA3);
            check("lock_d3", 32'(data_log[base+3]), 32'h55);
            check("lock_l0", 32'(lock_log[base]),   32'd1);
            check("lock_l1", 32'(lock_log[base+1]), 32'd1);
            check("lock_l2", 32'(lock_log[base+2]), 32'd0);
            check("lock_l3", 32'(lock_log[base+3]), 32'd0);
        end
        check("lock_end_locked", 32'(locked), 32'h0);

        // Transmitter never starts: timeout after ACK_TIMEOUT WAIT_ACK cycles
        tx_mode = 1;
        set_req(1, 1, 8'h3C, 0);
        wait_ready(1, 50, "to_ready");
        tick();
        set_req(1, 0, 8'h00, 0);
        set_req(3, 1, 8'hC3, 1);
        @(negedge clk);
        check("to_issue_dv", 32'(tx_data_valid), 32'h1);
        check("to_locked", 32'(locked), 32'h1);
        c = 0;
        while (!timeout_err && c < 40) begin @(negedge clk); c++; end
        check("to_cycles", 32'(c), 32'd16);
        check("to_lock_cleared", 32'(locked), 32'h0);
        check("to_next_ready", 32'(req_ready), 32'h8);
        tx_mode = 0;
        tick();
        set_req(3, 0, 8'h00, 0);
        wait_idle(100, "to_idle");
        check("to_next_grant", 32'(grant_id), 32'd3);
        check("to_sticky", 32'(timeout_err), 32'h1);

        // External busy in IDLE blocks selection until it falls
        tick();
        tx_force = 1;
        set_req(0, 1, 8'h5A, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("busy_no_ready", 32'(req_ready), 32'h0);
            check("busy_no_dv", 32'(tx_data_valid), 32'h0);
        end
        tick();
        tx_force = 0;
        @(negedge clk);
        check("busy_release_ready", 32'(req_ready), 32'h1);
        tick();
        set_req(0, 0, 8'h00, 0);
        @(negedge clk);
        check("busy_release_dv", 32'(tx_data_valid), 32'h1);
        check("busy_release_data", 32'(tx_parallel_data), 32'h5A);
        wait_idle(100, "busy_idle");

        // Reset while in WAIT_DONE with the lock held
        tx_len = 20;
        set_req(2, 1, 8'h77, 0);
        wait_ready(2, 50, "rst_mid_ready");
        tick();
        set_req(2, 0, 8'h00, 0);
        c = 0;
        while (!m_started && c < 20) begin tick(); c++; end
        if (!m_started) bound_fail("rst_mid_started");
        check("rst_mid_locked", 32'(locked), 32'h1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'h0);
        check("rst_mid_dv", 32'(tx_data_valid), 32'h0);
        check("rst_mid_data", 32'(tx_parallel_data), 32'h0);
        check("rst_mid_grant", 32'(grant_id), 32'(NUM_REQ - 1));
        check("rst_mid_unlocked", 32'(locked), 32'h0);
        check("rst_mid_terr", 32'(timeout_err), 32'h0);
        tick();
        tick();
        tx_len = 4;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 8'(8'h20 + i), 1);
        reset = 1'b1;
        base = grant_log.size();
        wait_accepts(base + 1, 100, "rst_mid_regrant");
        req_valid = '0;
        if (grant_log.size() > base) check("rst_mid_first_grant", 32'(grant_log[base]), 32'd0);
        wait_idle(100, "rst_mid_idle");

        // Requester drops valid right after acceptance
        tx_len = 6;
        set_req(1, 1, 8'h9E, 1);
        wait_ready(1, 50, "drop_ready");
        tick();
        set_req(1, 0, 8'h00, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!m_inflight) break;
            check("drop_data_held", 32'(tx_parallel_data), 32'h9E);
        end
        wait_idle(100, "drop_idle");
        check("drop_grant", 32'(grant_log[grant_log.size()-1]), 32'd1);
        check("drop_sent", 32'(data_log[data_log.size()-1]), 32'h9E);

        // Randomized traffic
        frc_left = 0;
        for (int k = 0; k < 1500; k++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            tx_delay = int'($urandom_range(0, 2));
            tx_len   = int'($urandom_range(1, 5));
            tx_mode  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            if (frc_left > 0) frc_left--;
            else if ($urandom_range(0, 60) == 0) frc_left = int'($urandom_range(1, 4));
            tx_force = (frc_left > 0);
            if (k == 700) reset = 1'b0;
            if (k == 702) reset = 1'b1;
        end
        tick();
        req_valid = '0;
        tx_force  = 0;
        tx_mode   = 0;
        wait_idle(200, "final_idle");
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, byte width of each requester and of the transmitter data.
REQ-003 Parameter ACK_TIMEOUT, default 15, maximum cycles to wait for tx_busy to rise after issue.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte available.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  byte is the final byte of requester's packet.
REQ-009 req_ready  output  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted.
REQ-010 tx_data_valid  output  1  one-cycle pulse to transmitter data_valid.
REQ-011 tx_parallel_data  output  DATA_WIDTH  byte to transmitter, held stable from issue until tx_busy falls.
REQ-012 tx_busy  input  1  transmitter busy.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.
REQ-014 locked  output  1  packet lock active.
REQ-015 timeout_err  output  1  sticky: transmitter failed to start.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-017 IDLE: if lock active, select only grant_id, wait for its req_valid; else round-robin from (last grant + 1) mod NUM_REQ over req_valid; no valid -> stay IDLE.
REQ-018 On selection in IDLE: register byte into tx_parallel_data, update grant_id, pulse req_ready[grant] same cycle, go ISSUE.
REQ-019 Selection SHALL NOT occur while tx_busy is high; stay IDLE.
REQ-020 ISSUE: tx_data_valid=1 for exactly this one cycle; go WAIT_ACK, clear ack counter.
REQ-021 WAIT_ACK: tx_busy=1 -> WAIT_DONE; counter reaches ACK_TIMEOUT -> set timeout_err, clear lock, go IDLE.
REQ-022 WAIT_DONE: tx_busy=0 -> IDLE; no upper bound on wait.
REQ-023 Lock: set when accepted byte has req_last=0; cleared when accepted byte has req_last=1 or on timeout.
REQ-024 While locked, other requesters' req_valid SHALL be ignored, regardless of priority.
REQ-025 Round-robin pointer advances only on acceptance; ties resolved strictly by rotation, never fixed priority.
REQ-026 req_ready is zero in all states other than the accepting IDLE cycle; at most one bit set.
REQ-027 Minimum spacing between tx_data_valid pulses is 4 cycles (IDLE, ISSUE, WAIT_ACK, WAIT_DONE).
REQ-028 Deasserting req_valid after acceptance has no effect on an in-flight byte.
REQ-029 timeout_err cleared only by reset.

Reset
REQ-030 reset low: state IDLE, req_ready=0, tx_data_valid=0, tx_parallel_data=0, grant_id=NUM_REQ-1 (first arbitration favours requester 0), locked=0, timeout_err=0, counter=0.
REQ-031 Reset mid-operation aborts the in-flight byte silently; no req_ready or tx_data_valid after release until a new selection.
REQ-032 First selection possible in the first clock edge after reset deasserts.

Verification
REQ-033 After reset, req_valid=4'b1111, all req_last=1, model busy 1 cycle after issue for 10 cycles -> grants 0,1,2,3,0 in order, one tx_data_valid per byte.
REQ-034 Requester 2 sends 3 bytes 0xA1,0xA2,0xA3 (req_last on third) while requester 0 valid -> locked=1 from first to third byte, bytes 0xA1..0xA3 issued contiguously, then requester 0 granted, locked=0.
REQ-035 tx_busy stuck 0 after issue -> after ACK_TIMEOUT=15 cycles in WAIT_ACK timeout_err=1, state IDLE, lock cleared, next request served.
REQ-036 tx_busy held high externally in IDLE with req_valid=1 -> no req_ready, no tx_data_valid until tx_busy falls.
REQ-037 Reset asserted in WAIT_DONE with lock active -> all outputs to reset values immediately, locked=0, grant restarts at requester 0.
REQ-038 Requester 1 deasserts req_valid the cycle after req_ready -> tx_parallel_data unchanged until tx_busy falls, byte still transmitted.
